mem_hs_taint_param: RTL
=======================

// Module: mem_hs_taint_param
// PURPOSE
// Parametrised single-port memory with valid/ready request and response handshakes,
// configurable access latency, and built-in per-word taint shadow tracking.
// Successor to the fixed 16x8 two-cycle memory: adds width/depth/latency parameters,
// response backpressure, and conservative taint tracking for tainted-address writes.
// Sits behind a requester that issues single read/write transactions; used for IFT proofs.
// PARAMETERS
// DW        8  data word width in bits
// AW        4  address width in bits; DEPTH = 2**AW words
// LAT       2  cycles from request accept to out_valid; legal range 1..15
// TAINT_EN  1  1 = taint shadow logic live; 0 = all *_t outputs tied to 0
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   asynchronous reset, active-low
// addr         in   AW  request address
// data_in      in   DW  write data
// we           in   1   1 = write, 0 = read
// in_valid     in   1   request valid
// in_ready     out  1   request ready
// data_out     out  DW  response data; 0 whenever out_valid = 0
// out_valid    out  1   response valid
// out_ready    in   1   response accepted by consumer
// addr_t, data_in_t, we_t, in_valid_t, out_ready_t   in   1 each  input taint bits
// data_out_t, out_valid_t, in_ready_t                out  1 each  output taint bits
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, in_ready=1, out_valid=0, data_out=0, all taint regs
//   and mem_t cleared to 0; mem data array NOT cleared. Pending transaction dropped, no write.
// - FSM IDLE/BUSY/RESP. in_ready = (state==IDLE). Accept = in_valid & in_ready:
//   latch addr, data_in, we; LAT=1 -> RESP next cycle, else BUSY with cnt = LAT-1.
// - BUSY: cnt decrements each cycle; cnt==1 -> RESP next cycle. No early exit.
// - Entry to RESP (accept cycle + LAT): write committed if we; data_out registered as
//   mem[addr_buf] (write returns the newly written data); out_valid=1.
// - RESP: out_valid and data_out held stable until out_ready=1; then IDLE next cycle,
//   out_valid=0, data_out=0. No accept in the RESP cycle; min period LAT+1 cycles.
// - in_valid while not ready is ignored (no queueing). Address always in range (2**AW).
// - Taint (TAINT_EN=1), all sticky until reset:
//   ctl_t <= ctl_t | in_valid_t | (state!=IDLE & out_ready_t).
//   On accept: addr_b_t/we_b_t/data_b_t <= field_t | ctl_t.
//   At commit: word addr_buf: mem_t |= ctl_t|we_b_t|addr_b_t|(we & data_b_t); a write
//   (we=1) with clean control overwrites mem_t with data_b_t|addr_b_t.
//   If addr_b_t & (we | we_b_t): ALL mem_t bits set to 1 (tainted-address write).
//   data_out_t registered at RESP entry = mem_t[addr_buf]' | addr_b_t | ctl_t; cleared
//   on leaving RESP. out_valid_t = in_ready_t = ctl_t.
// - TAINT_EN=0: no taint state synthesised; all *_t outputs constant 0.
// TESTING
// - LAT=2: write 0xA5 @3 at cycle 0 -> out_valid cycle 2, data_out=0xA5; read @3 -> 0xA5.
// - out_ready low 5 cycles in RESP -> out_valid/data_out stable, in_ready=0 throughout.
// - LAT=1 and LAT=7: accept at t -> out_valid exactly t+1 / t+7; back-to-back period LAT+1.
// - rst low during BUSY of write 0x3C @5 -> IDLE immediately; read @5 returns old value.
// - data_in_t=1 write @2, then clean read @4 -> data_out_t=0; read @2 -> data_out_t=1.
// - addr_t=1 on write -> every later read has data_out_t=1; in_valid_t=1 -> in_ready_t=1 sticky.

Source files
------------

// File: rtl/mem_hs_taint_param.sv
// Single-port memory with request/response valid-ready handshakes, a configurable access
// latency, and a conservative one-bit-per-word taint shadow for information-flow tracking.
module mem_hs_taint_param #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int LAT      = 2,
  parameter int TAINT_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          we,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          addr_t,
  input  logic          data_in_t,
  input  logic          we_t,
  input  logic          in_valid_t,
  input  logic          out_ready_t,
  output logic          data_out_t,
  output logic          out_valid_t,
  output logic          in_ready_t
);

  localparam int         DEPTH    = 1 << AW;
  localparam bit         LAT1     = (LAT == 1);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_buf_q;
  logic [DW-1:0] data_buf_q;
  logic          we_buf_q;
  logic [DW-1:0] data_out_q;
  logic          out_valid_q;
  logic [DW-1:0] mem [DEPTH];

  logic          idle;
  logic          accept;
  logic          commit;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_data;
  logic          eff_we;
  logic [DW-1:0] rd_data;

  // With LAT=1 the commit lands on the accept edge, before the buffers hold the request,
  // so the commit path takes the live inputs while idle and the buffers otherwise.
  assign idle     = (state_q == IDLE);
  assign accept   = in_valid & idle;
  assign commit   = (idle & accept & LAT1) | ((state_q == BUSY) & (cnt_q == 4'd1));
  assign eff_addr = idle ? addr    : addr_buf_q;
  assign eff_data = idle ? data_in : data_buf_q;
  assign eff_we   = idle ? we      : we_buf_q;
  assign rd_data  = eff_we ? eff_data : mem[eff_addr];

  assign in_ready  = idle;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (LAT1) begin
            state_q     <= RESP;
            out_valid_q <= 1'b1;
            data_out_q  <= rd_data;
          end else begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        BUSY: if (cnt_q == 4'd1) begin
          state_q     <= RESP;
          out_valid_q <= 1'b1;
          data_out_q  <= rd_data;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          data_out_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request buffers and storage carry no reset; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_buf_q <= addr;
      data_buf_q <= data_in;
      we_buf_q   <= we;
    end
    if (rst && commit && eff_we)
      mem[eff_addr] <= eff_data;
  end

  if (TAINT_EN != 0) begin : g_taint
    logic             ctl_t_q;
    logic             addr_b_t_q;
    logic             we_b_t_q;
    logic             data_b_t_q;
    logic             dout_t_q;
    logic [DEPTH-1:0] mem_t_q;
    logic [DEPTH-1:0] mem_t_nxt;
    logic             c_addr_t;
    logic             c_we_t;
    logic             c_data_t;

    assign c_addr_t = idle ? (addr_t    | ctl_t_q) : addr_b_t_q;
    assign c_we_t   = idle ? (we_t      | ctl_t_q) : we_b_t_q;
    assign c_data_t = idle ? (data_in_t | ctl_t_q) : data_b_t_q;

    // Taint of a write target with an untainted address and control is replaced; any doubt
    // accumulates, and a write through a tainted address may have hit any word.
    always_comb begin
      mem_t_nxt = mem_t_q;
      if (eff_we && !ctl_t_q && !c_we_t)
        mem_t_nxt[eff_addr] = c_data_t | c_addr_t;
      else
        mem_t_nxt[eff_addr] = mem_t_q[eff_addr] | ctl_t_q | c_we_t | c_addr_t
                              | (eff_we & c_data_t);
      if (c_addr_t && (eff_we || c_we_t))
        mem_t_nxt = '1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ctl_t_q    <= 1'b0;
        addr_b_t_q <= 1'b0;
        we_b_t_q   <= 1'b0;
        data_b_t_q <= 1'b0;
        dout_t_q   <= 1'b0;
        mem_t_q    <= '0;
      end else begin
        ctl_t_q <= ctl_t_q | in_valid_t | (!idle & out_ready_t);
        if (accept) begin
          addr_b_t_q <= addr_t    | ctl_t_q;
          we_b_t_q   <= we_t      | ctl_t_q;
          data_b_t_q <= data_in_t | ctl_t_q;
        end
        if (commit) begin
          mem_t_q  <= mem_t_nxt;
          dout_t_q <= mem_t_nxt[eff_addr] | c_addr_t | ctl_t_q;
        end else if ((state_q == RESP) && out_ready) begin
          dout_t_q <= 1'b0;
        end
      end
    end

    assign data_out_t  = dout_t_q;
    assign out_valid_t = ctl_t_q;
    assign in_ready_t  = ctl_t_q;
  end else begin : g_no_taint
    assign data_out_t  = 1'b0;
    assign out_valid_t = 1'b0;
    assign in_ready_t  = 1'b0;
  end

endmodule
